// File: rtl/lpc_reg_pkg.sv
// lpc_reg_pkg: register map, reset/mask tables and lock key shared by the LPC register bank.
package lpc_reg_pkg;

  localparam int STATUS_IDX = 1;
  localparam int IRQEN_IDX  = 2;
  localparam int LOCK_IDX   = 3;
  localparam int ERRCNT_IDX = 4;
  localparam int PROT_LO    = 5;
  localparam int PROT_HI    = 6;
  localparam int BASE_REGS  = 8;

  localparam logic [7:0] UNLOCK_KEY   = 8'hA5;
  localparam logic [3:0] FPGAID_CODE  = 4'hA;
  localparam logic [3:0] VERSION_CODE = 4'h3;

  // Entries 0..7 are the fixed map; indexes above that are generic scratch registers.
  localparam logic [7:0] RESET_VAL [BASE_REGS] = '{
    {FPGAID_CODE, VERSION_CODE}, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h3C, 8'h00
  };
  localparam logic [7:0] WR_MASK [BASE_REGS] = '{
    8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h1B
  };
  localparam logic [7:0] HW_MASK [BASE_REGS] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03
  };

  function automatic logic [7:0] resetVal(int idx);
    logic [31:0] v;
    v = idx;
    return (idx < BASE_REGS) ? RESET_VAL[v[2:0]] : v[7:0];
  endfunction

  function automatic logic [7:0] wrMask(int idx);
    logic [31:0] v;
    v = idx;
    return (idx < BASE_REGS) ? WR_MASK[v[2:0]] : 8'hFF;
  endfunction

  function automatic logic [7:0] hwMask(int idx);
    logic [31:0] v;
    v = idx;
    return (idx < BASE_REGS) ? HW_MASK[v[2:0]] : 8'hF0;
  endfunction

endpackage

// File: rtl/lpc_reg_wrlock.sv
// lpc_reg_wrlock: write-protect lock, dropped-write pulse and saturating error counter.
// Instantiated by lpc_reg_bank only when LPC_REG_WRLOCK_EN is defined.
module lpc_reg_wrlock
  import lpc_reg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic              o_drop,
  output logic              o_unlocked,
  output logic [7:0]        o_errCnt,
  output logic              o_wrBlocked
);

  logic       r_locked;
  logic [7:0] r_errCnt;
  logic       r_wrBlocked;
  logic       w_inProt;

  assign w_inProt   = (int'(i_addr) >= PROT_LO) && (int'(i_addr) <= PROT_HI);
  assign o_drop     = i_wr && r_locked && w_inProt;
  assign o_unlocked = ~r_locked;
  assign o_errCnt   = r_errCnt;
  assign o_wrBlocked = r_wrBlocked;

  // Any write other than the key re-locks; the counter saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_locked    <= 1'b1;
      r_errCnt    <= 8'h00;
      r_wrBlocked <= 1'b0;
    end else begin
      r_wrBlocked <= o_drop;
      if (i_wr && int'(i_addr) == LOCK_IDX) begin
        r_locked <= (i_data != UNLOCK_KEY);
      end
      if (i_wr && int'(i_addr) == ERRCNT_IDX) begin
        r_errCnt <= 8'h00;
      end else if (o_drop && r_errCnt != 8'hFF) begin
        r_errCnt <= r_errCnt + 8'h01;
      end
    end
  end

endmodule

// File: rtl/lpc_reg_bank.sv
// lpc_reg_bank: LPC register bank with masked SW/HW updates, W1C status and registered IRQ.
// Define LPC_REG_WRLOCK_EN to build the write-lock and error counter (lpc_reg_wrlock).
module lpc_reg_bank
  import lpc_reg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                       LpcClock,
  input  logic                       PciReset,
  input  logic [ADDR_W-1:0]          Addr,
  input  logic                       Wr,
  input  logic                       Rd,
  input  logic [DATA_W-1:0]          DataWrSW,
  input  logic [NUM_REGS-1:0]        HwWrEn,
  input  logic [NUM_REGS*DATA_W-1:0] HwWrData,
  input  logic [DATA_W-1:0]          HwSet,
  output logic [NUM_REGS*DATA_W-1:0] RegFlat,
  output logic [DATA_W-1:0]          DataRd,
  output logic                       RdValid,
  output logic                       Irq,
  output logic                       WrBlocked
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_next [NUM_REGS];
  logic [DATA_W-1:0] w_view [NUM_REGS];
  logic [DATA_W-1:0] w_rdData;
  logic [DATA_W-1:0] r_dataRd;
  logic [DATA_W-1:0] w_lockView;
  logic [DATA_W-1:0] w_errView;
  logic              r_armed;
  logic              r_rdValid;
  logic              r_irq;
  logic              w_wr;
  logic              w_rd;
  logic              w_drop;

  // Strobes are masked on the first edge after reset release.
  assign w_wr = Wr & r_armed;
  assign w_rd = Rd & r_armed;

`ifdef LPC_REG_WRLOCK_EN
  logic       w_unlocked;
  logic [7:0] w_errCnt;

  lpc_reg_wrlock #(.ADDR_W(ADDR_W)) u_wrlock (
    .i_clk       (LpcClock),
    .i_rst_n     (PciReset),
    .i_wr        (w_wr),
    .i_addr      (Addr),
    .i_data      (DataWrSW[7:0]),
    .o_drop      (w_drop),
    .o_unlocked  (w_unlocked),
    .o_errCnt    (w_errCnt),
    .o_wrBlocked (WrBlocked)
  );

  assign w_lockView = DATA_W'(w_unlocked);
  assign w_errView  = DATA_W'(w_errCnt);
`else
  assign w_drop     = 1'b0;
  assign w_lockView = '0;
  assign w_errView  = '0;
  assign WrBlocked  = 1'b0;
`endif

  // SW update applied first, then HW overlays its masked bits so HW wins on overlap.
  always_comb begin
    w_next = r_regs;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == STATUS_IDX) begin
        w_next[i] = (r_regs[i] & ~((w_wr && int'(Addr) == i) ? DataWrSW : '0)) | HwSet;
      end else begin
        if (w_wr && !w_drop && int'(Addr) == i) begin
          w_next[i] = (DATA_W'(wrMask(i)) & DataWrSW) | (~(DATA_W'(wrMask(i))) & r_regs[i]);
        end
        if (HwWrEn[i]) begin
          w_next[i] = (DATA_W'(hwMask(i)) & HwWrData[i*DATA_W +: DATA_W])
                    | (~(DATA_W'(hwMask(i))) & w_next[i]);
        end
      end
    end
  end

  always_comb begin
    w_view   = '{default: '0};
    RegFlat  = '0;
    w_rdData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == LOCK_IDX) begin
        w_view[i] = w_lockView;
      end else if (i == ERRCNT_IDX) begin
        w_view[i] = w_errView;
      end else begin
        w_view[i] = r_regs[i];
      end
      RegFlat[i*DATA_W +: DATA_W] = w_view[i];
      if (int'(Addr) == i) begin
        w_rdData = w_view[i];
      end
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(resetVal(i));
      end
      r_armed   <= 1'b0;
      r_dataRd  <= '0;
      r_rdValid <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_armed   <= 1'b1;
      r_rdValid <= w_rd;
      if (w_rd) begin
        r_dataRd <= w_rdData;
      end
      r_irq <= |(r_regs[STATUS_IDX] & r_regs[IRQEN_IDX]);
    end
  end

  assign DataRd  = r_dataRd;
  assign RdValid = r_rdValid;
  assign Irq     = r_irq;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// tb_lpc_reg_bank: randomized self-checking bench for lpc_reg_bank against a behavioural model.
// Lock and error-counter scenarios are compiled in when LPC_REG_WRLOCK_EN is defined.
module tb_lpc_reg_bank;
  import lpc_reg_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int FLAT_W   = NUM_REGS * DATA_W;

  logic                LpcClock = 1'b0;
  logic                PciReset = 1'b1;
  logic [ADDR_W-1:0]   Addr;
  logic                Wr;
  logic                Rd;
  logic [DATA_W-1:0]   DataWrSW;
  logic [NUM_REGS-1:0] HwWrEn;
  logic [FLAT_W-1:0]   HwWrData;
  logic [DATA_W-1:0]   HwSet;
  logic [FLAT_W-1:0]   RegFlat;
  logic [DATA_W-1:0]   DataRd;
  logic                RdValid;
  logic                Irq;
  logic                WrBlocked;

  lpc_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .Addr     (Addr),
    .Wr       (Wr),
    .Rd       (Rd),
    .DataWrSW (DataWrSW),
    .HwWrEn   (HwWrEn),
    .HwWrData (HwWrData),
    .HwSet    (HwSet),
    .RegFlat  (RegFlat),
    .DataRd   (DataRd),
    .RdValid  (RdValid),
    .Irq      (Irq),
    .WrBlocked(WrBlocked)
  );

  always #5 LpcClock = ~LpcClock;

  // Reference model state
  logic [7:0] mRegs [NUM_REGS];
  logic       mLocked;
  logic [7:0] mErr;
  logic [7:0] mDataRd;
  logic       mRdValid;
  logic       mIrq;
  logic       mWrBlocked;
  logic       mArmed;
  int         nChecks = 0;
  int         nErrors = 0;

  // Register map as seen by software: ID, status, irq enable, lock, errcnt, two protected, masked.
  function automatic logic [7:0] tbReset(int i);
    logic [31:0] v;
    v = i;
    case (i)
      0:       return 8'hA3;
      5:       return 8'h5A;
      6:       return 8'h3C;
      1, 2, 3, 4, 7: return 8'h00;
      default: return v[7:0];
    endcase
  endfunction

  function automatic logic [7:0] tbWrMask(int i);
    case (i)
      0, 3, 4: return 8'h00;
      7:       return 8'h1B;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] tbHwMask(int i);
    if (i == 7) return 8'h03;
    if (i >= 8) return 8'hF0;
    return 8'h00;
  endfunction

  function automatic logic [7:0] viewOf(int i);
`ifdef LPC_REG_WRLOCK_EN
    if (i == 3) return mLocked ? 8'h00 : 8'h01;
    if (i == 4) return mErr;
`else
    if (i == 3 || i == 4) return 8'h00;
`endif
    return mRegs[i];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_REGS; i++) mRegs[i] = tbReset(i);
    mLocked = 1'b1;
    mErr = 8'h00;
    mDataRd = 8'h00;
    mRdValid = 1'b0;
    mIrq = 1'b0;
    mWrBlocked = 1'b0;
    mArmed = 1'b0;
  endtask

  task automatic modelStep();
    logic [7:0] old [NUM_REGS];
    logic [7:0] upd;
    logic       wr;
    logic       rd;
    logic       blocked;
    int         a;
    old = mRegs;
    wr = Wr && mArmed;
    rd = Rd && mArmed;
    a = int'(Addr);
    if (rd) mDataRd = (a < NUM_REGS) ? viewOf(a) : 8'h00;
    mRdValid = rd;
    mIrq = |(old[1] & old[2]);
    blocked = 1'b0;
`ifdef LPC_REG_WRLOCK_EN
    blocked = wr && mLocked && a >= 5 && a <= 6;
`endif
    mWrBlocked = blocked;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 1) begin
        mRegs[i] = (old[i] & ~((wr && a == 1) ? DataWrSW : 8'h00)) | HwSet;
      end else begin
        upd = old[i];
        if (wr && a == i && !blocked) upd = (tbWrMask(i) & DataWrSW) | (~tbWrMask(i) & upd);
        if (HwWrEn[i]) upd = (tbHwMask(i) & HwWrData[i*8 +: 8]) | (~tbHwMask(i) & upd);
        mRegs[i] = upd;
      end
    end
    if (wr && a == 3) mLocked = (DataWrSW != 8'hA5);
    if (wr && a == 4) mErr = 8'h00;
    else if (blocked && mErr != 8'hFF) mErr = mErr + 8'h01;
    mArmed = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [FLAT_W-1:0] obs,
                             input logic [FLAT_W-1:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [FLAT_W-1:0] flat;
    flat = '0;
    for (int i = 0; i < NUM_REGS; i++) flat[i*8 +: 8] = viewOf(i);
    checkOutput("RegFlat", RegFlat, flat);
    checkOutput("DataRd", FLAT_W'(DataRd), FLAT_W'(mDataRd));
    checkOutput("RdValid", FLAT_W'(RdValid), FLAT_W'(mRdValid));
    checkOutput("Irq", FLAT_W'(Irq), FLAT_W'(mIrq));
    checkOutput("WrBlocked", FLAT_W'(WrBlocked), FLAT_W'(mWrBlocked));
  endtask

  task automatic tick();
    @(posedge LpcClock);
    modelStep();
    @(negedge LpcClock);
    checkAll();
  endtask

  task automatic setIdle();
    Wr = 1'b0;
    Rd = 1'b0;
    Addr = '0;
    DataWrSW = '0;
    HwWrEn = '0;
    HwWrData = '0;
    HwSet = '0;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input int addr,
                               input logic [7:0] data);
    Wr = wr;
    Rd = rd;
    Addr = 8'(addr);
    DataWrSW = data;
    tick();
    Wr = 1'b0;
    Rd = 1'b0;
    HwWrEn = '0;
    HwSet = '0;
  endtask

  task automatic assertReset();
    PciReset = 1'b0;
    #1;
    modelReset();
    checkAll();
  endtask

  // Release with a write strobe on the same cycle; that strobe must have no effect.
  task automatic releaseReset();
    repeat (2) @(negedge LpcClock);
    setIdle();
    Wr = 1'b1;
    Addr = 8'd7;
    DataWrSW = 8'hFF;
    PciReset = 1'b1;
    tick();
    setIdle();
    checkOutput("ignoredStrobe", FLAT_W'(RegFlat[7*8 +: 8]), FLAT_W'(8'h00));
  endtask

  initial begin
    setIdle();
    #2;
    assertReset();
    checkOutput("rstDataRd", FLAT_W'(DataRd), '0);
    checkOutput("rstIdReg", FLAT_W'(RegFlat[7:0]), FLAT_W'(8'hA3));
    releaseReset();

    for (int a = 0; a < NUM_REGS; a++) begin
      applyStimulus(1'b0, 1'b1, a, 8'h00);
      checkOutput("resetRead", FLAT_W'(DataRd), FLAT_W'(tbReset(a)));
    end
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
    checkOutput("oorRead", FLAT_W'(DataRd), '0);
    checkOutput("oorValid", FLAT_W'(RdValid), FLAT_W'(1'b1));

    applyStimulus(1'b1, 1'b0, 7, 8'hFF);
    applyStimulus(1'b0, 1'b1, 7, 8'h00);
    checkOutput("wrMask", FLAT_W'(DataRd), FLAT_W'(8'h1B));
    HwWrEn[7] = 1'b1;
    HwWrData[7*8 +: 8] = 8'h02;
    applyStimulus(1'b1, 1'b0, 7, 8'hFF);
    checkOutput("hwWins", FLAT_W'(RegFlat[7*8 +: 8]), FLAT_W'(8'h1A));
    applyStimulus(1'b1, 1'b0, 0, 8'h55);
    checkOutput("idReadOnly", FLAT_W'(RegFlat[7:0]), FLAT_W'(8'hA3));

    applyStimulus(1'b1, 1'b0, 2, 8'h04);
    HwSet = 8'h04;
    applyStimulus(1'b0, 1'b0, 0, 8'h00);
    applyStimulus(1'b0, 1'b0, 0, 8'h00);
    checkOutput("irqSet", FLAT_W'(Irq), FLAT_W'(1'b1));
    HwSet = 8'h04;
    applyStimulus(1'b1, 1'b0, 1, 8'h04);
    checkOutput("setBeatsClr", FLAT_W'(RegFlat[1*8 +: 8]), FLAT_W'(8'h04));
    applyStimulus(1'b1, 1'b0, 1, 8'h04);
    checkOutput("w1c", FLAT_W'(RegFlat[1*8 +: 8]), FLAT_W'(8'h00));
    applyStimulus(1'b0, 1'b0, 0, 8'h00);
    checkOutput("irqClr", FLAT_W'(Irq), FLAT_W'(1'b0));

    applyStimulus(1'b1, 1'b1, 2, 8'h77);
    checkOutput("rdWrOld", FLAT_W'(DataRd), FLAT_W'(8'h04));
    applyStimulus(1'b0, 1'b1, 2, 8'h00);
    checkOutput("rdWrNew", FLAT_W'(DataRd), FLAT_W'(8'h77));

`ifdef LPC_REG_WRLOCK_EN
    applyStimulus(1'b1, 1'b0, 5, 8'h11);
    checkOutput("wrBlockedPulse", FLAT_W'(WrBlocked), FLAT_W'(1'b1));
    applyStimulus(1'b0, 1'b1, 5, 8'h00);
    checkOutput("protHeld", FLAT_W'(DataRd), FLAT_W'(8'h5A));
    applyStimulus(1'b0, 1'b1, 4, 8'h00);
    checkOutput("errCnt1", FLAT_W'(DataRd), FLAT_W'(8'h01));
    for (int n = 0; n < 300; n++) applyStimulus(1'b1, 1'b0, 5, 8'($urandom));
    applyStimulus(1'b0, 1'b1, 4, 8'h00);
    checkOutput("errCntSat", FLAT_W'(DataRd), FLAT_W'(8'hFF));
    applyStimulus(1'b1, 1'b0, 3, 8'hA5);
    applyStimulus(1'b0, 1'b1, 3, 8'h00);
    checkOutput("unlocked", FLAT_W'(DataRd), FLAT_W'(8'h01));
    applyStimulus(1'b1, 1'b0, 5, 8'h11);
    applyStimulus(1'b0, 1'b1, 5, 8'h00);
    checkOutput("protWritten", FLAT_W'(DataRd), FLAT_W'(8'h11));
    applyStimulus(1'b1, 1'b0, 4, 8'h33);
    applyStimulus(1'b0, 1'b1, 4, 8'h00);
    checkOutput("errCntClr", FLAT_W'(DataRd), FLAT_W'(8'h00));
    applyStimulus(1'b1, 1'b0, 3, 8'h5A);
    applyStimulus(1'b0, 1'b1, 3, 8'h00);
    checkOutput("relocked", FLAT_W'(DataRd), FLAT_W'(8'h00));
`endif

    for (int n = 0; n < 1500; n++) begin
      Wr = ($urandom_range(0, 2) == 0);
      Rd = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) Addr = 8'($urandom);
      else Addr = 8'($urandom_range(0, NUM_REGS - 1));
      if (int'(Addr) == 3 && $urandom_range(0, 1) == 1) DataWrSW = 8'hA5;
      else DataWrSW = 8'($urandom);
      for (int i = 0; i < NUM_REGS; i++) HwWrEn[i] = ($urandom_range(0, 7) == 0);
      for (int w = 0; w < FLAT_W / 32; w++) HwWrData[w*32 +: 32] = $urandom;
      HwSet = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      tick();
      if (n == 700) begin
        Wr = 1'b1;
        Addr = 8'd9;
        DataWrSW = 8'hC3;
        #2;
        assertReset();
        checkOutput("midRstReg9", FLAT_W'(RegFlat[9*8 +: 8]), FLAT_W'(8'h09));
        releaseReset();
      end
    end
    setIdle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
